// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned InstBus = 32;
  localparam int unsigned AddrBus = 32;

  localparam logic [AddrBus-1:0] PcIncr         = AddrBus'(4);
  localparam logic [AddrBus-1:0] DefaultResetPc = '0;

  typedef enum logic [0:0] {
    StIdle,
    StWaitMem
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Queue-push and memory-fetch signals of the fetch unit; master is the fetch unit side.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic               IF_S;
  logic [InstBus-1:0] IF_Inst;
  logic [AddrBus-1:0] IF_pc;
  logic               IQ_full;
  logic               MC_req;
  logic [AddrBus-1:0] MC_addr;
  logic               MC_valid;
  logic [InstBus-1:0] MC_inst;

  modport master (
    output IF_S, IF_Inst, IF_pc, MC_req, MC_addr,
    input  IQ_full, MC_valid, MC_inst
  );

  modport slave (
    input  IF_S, IF_Inst, IF_pc, MC_req, MC_addr,
    output IQ_full, MC_valid, MC_inst
  );

endinterface

// File: rtl/instruction_fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup port, single-write fill port.
module instruction_fetch_icache
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned LINES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AddrBus-1:2] lookup_addr,
  output logic               hit,
  output logic [InstBus-1:0] rd_data,
  input  logic               fill_en,
  input  logic [AddrBus-1:2] fill_addr,
  input  logic [InstBus-1:0] fill_data
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = AddrBus - 2 - IdxW;

  logic [LINES-1:0]   valid_q;
  logic [TagW-1:0]    tag_q  [LINES];
  logic [InstBus-1:0] data_q [LINES];

  logic [IdxW-1:0] lk_idx, fill_idx;
  logic [TagW-1:0] lk_tag, fill_tag;

  assign lk_idx   = lookup_addr[IdxW+1:2];
  assign lk_tag   = lookup_addr[AddrBus-1:IdxW+2];
  assign fill_idx = fill_addr[IdxW+1:2];
  assign fill_tag = fill_addr[AddrBus-1:IdxW+2];

  assign hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign rd_data = data_q[lk_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit with flush/redirect and queue back-pressure.
// Define ICACHE_EN to compile in the direct-mapped instruction cache.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [AddrBus-1:0] RESET_PC     = DefaultResetPc,
  parameter int unsigned        ICACHE_LINES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clr,
  input  logic [AddrBus-1:0]  clr_pc,
  instruction_fetch_if.master bus
);

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of 2");
  end

  fetch_state_e       state_q, state_d;
  logic               discard_q, discard_d;
  logic [AddrBus-1:0] pc_q, pc_d;
  logic               if_s_q, if_s_d;
  logic [InstBus-1:0] if_inst_q, if_inst_d;
  logic [AddrBus-1:0] if_pc_q, if_pc_d;
  logic               mc_req_q, mc_req_d;
  logic [AddrBus-1:0] mc_addr_q, mc_addr_d;

  logic               cache_hit;
  logic [InstBus-1:0] cache_data;

`ifdef ICACHE_EN
  logic fill_en;
  // Every completed memory fetch fills, even one whose push is discarded.
  assign fill_en = rdy && (state_q == StWaitMem) && bus.MC_valid;

  instruction_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(pc_q[AddrBus-1:2]),
    .hit        (cache_hit),
    .rd_data    (cache_data),
    .fill_en    (fill_en),
    .fill_addr  (mc_addr_q[AddrBus-1:2]),
    .fill_data  (bus.MC_inst)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    if_s_d    = 1'b0;
    if_inst_d = if_inst_q;
    if_pc_d   = if_pc_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;

    if (!rdy) begin
      if_s_d = 1'b0;
    end else if (clr) begin
      pc_d = clr_pc;
      if (state_q == StWaitMem) begin
        // A same-cycle response is consumed as the discarded one.
        if (bus.MC_valid) begin
          mc_req_d  = 1'b0;
          discard_d = 1'b0;
          state_d   = StIdle;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        StIdle: begin
          // Waiting for the previous push to clear keeps one push in flight.
          if (!bus.IQ_full && !if_s_q) begin
            if (cache_hit) begin
              if_s_d    = 1'b1;
              if_inst_d = cache_data;
              if_pc_d   = pc_q;
              pc_d      = pc_q + PcIncr;
            end else begin
              mc_req_d  = 1'b1;
              mc_addr_d = pc_q;
              state_d   = StWaitMem;
            end
          end
        end
        StWaitMem: begin
          if (bus.MC_valid) begin
            mc_req_d = 1'b0;
            state_d  = StIdle;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              if_s_d    = 1'b1;
              if_inst_d = bus.MC_inst;
              if_pc_d   = mc_addr_q;
              pc_d      = pc_q + PcIncr;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      pc_q      <= RESET_PC;
      if_s_q    <= 1'b0;
      if_inst_q <= '0;
      if_pc_q   <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      if_s_q    <= if_s_d;
      if_inst_q <= if_inst_d;
      if_pc_q   <= if_pc_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
    end
  end

  assign bus.IF_S    = if_s_q;
  assign bus.IF_Inst = if_inst_q;
  assign bus.IF_pc   = if_pc_q;
  assign bus.MC_req  = mc_req_q;
  assign bus.MC_addr = mc_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; expectations follow the ICACHE_EN setting of the build.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic [31:0] clr_pc;
  int          errors = 0;
  int          checks = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC    (32'h0),
    .ICACHE_LINES(256)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clr   (clr),
    .clr_pc(clr_pc),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; clr_pc = '0;
    bus.IQ_full = 1'b0; bus.MC_valid = 1'b0; bus.MC_inst = '0;
    step();
    step();
    chk("rst_if_s", {31'b0, bus.IF_S}, 32'd0);
    chk("rst_if_inst", bus.IF_Inst, 32'h0);
    chk("rst_if_pc", bus.IF_pc, 32'h0);
    chk("rst_mc_req", {31'b0, bus.MC_req}, 32'd0);
    chk("rst_mc_addr", bus.MC_addr, 32'h0);

    // First fetch from the reset PC, response after 3 cycles.
    rst = 1'b0;
    step();
    chk("f0_req", {31'b0, bus.MC_req}, 32'd1);
    chk("f0_addr", bus.MC_addr, 32'h0);
    step();
    step();
    chk("f0_req_held", {31'b0, bus.MC_req}, 32'd1);
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_0013;
    step();
    chk("f0_push", {31'b0, bus.IF_S}, 32'd1);
    chk("f0_inst", bus.IF_Inst, 32'h13);
    chk("f0_pc", bus.IF_pc, 32'h0);
    chk("f0_req_drop", {31'b0, bus.MC_req}, 32'd0);
    bus.MC_valid = 1'b0;
    step();
    chk("f0_pulse_end", {31'b0, bus.IF_S}, 32'd0);
    chk("f0_gap_req", {31'b0, bus.MC_req}, 32'd0);
    step();
    chk("f1_req", {31'b0, bus.MC_req}, 32'd1);
    chk("f1_addr", bus.MC_addr, 32'h4);
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_00AA;
    step();
    chk("f1_push", {31'b0, bus.IF_S}, 32'd1);
    chk("f1_pc", bus.IF_pc, 32'h4);

    // Queue full for 10 cycles stalls issue.
    bus.MC_valid = 1'b0; bus.IQ_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("full_req", {31'b0, bus.MC_req}, 32'd0);
      chk("full_if_s", {31'b0, bus.IF_S}, 32'd0);
    end
    bus.IQ_full = 1'b0;
    step();
    chk("resume_req", {31'b0, bus.MC_req}, 32'd1);
    chk("resume_addr", bus.MC_addr, 32'h8);

    // Redirect while waiting: response discarded, refetch at target.
    clr = 1'b1; clr_pc = 32'h100;
    step();
    chk("clrw_if_s", {31'b0, bus.IF_S}, 32'd0);
    chk("clrw_req_kept", {31'b0, bus.MC_req}, 32'd1);
    chk("clrw_addr_kept", bus.MC_addr, 32'h8);
    clr = 1'b0;
    step();
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_DEAD;
    step();
    chk("disc_no_push", {31'b0, bus.IF_S}, 32'd0);
    chk("disc_req_drop", {31'b0, bus.MC_req}, 32'd0);
    chk("disc_pc_hold", bus.IF_pc, 32'h4);
    bus.MC_valid = 1'b0;
    step();
    chk("redir_req", {31'b0, bus.MC_req}, 32'd1);
    chk("redir_addr", bus.MC_addr, 32'h100);

    // Global stall while waiting.
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'b0, bus.MC_req}, 32'd1);
      chk("stall_addr", bus.MC_addr, 32'h100);
      chk("stall_if_s", {31'b0, bus.IF_S}, 32'd0);
    end
    rdy = 1'b1;
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_1234;
    step();
    chk("stall_push", {31'b0, bus.IF_S}, 32'd1);
    chk("stall_push_pc", bus.IF_pc, 32'h100);
    chk("stall_push_inst", bus.IF_Inst, 32'h1234);
    bus.MC_valid = 1'b0;
    step();
    step();
    chk("f104_addr", bus.MC_addr, 32'h104);

    // Redirect on the same cycle as the response.
    clr = 1'b1; clr_pc = 32'h40; bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_5555;
    step();
    chk("clrv_no_push", {31'b0, bus.IF_S}, 32'd0);
    chk("clrv_req_drop", {31'b0, bus.MC_req}, 32'd0);
    clr = 1'b0; bus.MC_valid = 1'b0;
    step();
    chk("clrv_req", {31'b0, bus.MC_req}, 32'd1);
    chk("clrv_addr", bus.MC_addr, 32'h40);
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_0077;
    step();
    chk("f40_pc", bus.IF_pc, 32'h40);
    bus.MC_valid = 1'b0;

    // Asynchronous reset mid-fetch; late response ignored.
    clr = 1'b1; clr_pc = 32'h200;
    step();
    clr = 1'b0;
    step();
    chk("f200_addr", bus.MC_addr, 32'h200);
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, bus.MC_req}, 32'd0);
    chk("arst_addr", bus.MC_addr, 32'h0);
    chk("arst_if_pc", bus.IF_pc, 32'h0);
    step();
    rst = 1'b0; bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_0BAD;
    step();
    chk("late_no_push", {31'b0, bus.IF_S}, 32'd0);
    chk("late_req", {31'b0, bus.MC_req}, 32'd1);
    chk("late_addr", bus.MC_addr, 32'h0);
    bus.MC_inst = 32'h0000_0013;
    step();
    chk("r0_push", {31'b0, bus.IF_S}, 32'd1);
    chk("r0_inst", bus.IF_Inst, 32'h13);
    bus.MC_valid = 1'b0;

    // PC wrap at the top of the address space, then back to 0.
    clr = 1'b1; clr_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_clr_if_s", {31'b0, bus.IF_S}, 32'd0);
    clr = 1'b0;
    step();
    chk("wrap_addr", bus.MC_addr, 32'hFFFF_FFFC);
    bus.MC_valid = 1'b1; bus.MC_inst = 32'h0000_0099;
    step();
    chk("wrap_push_pc", bus.IF_pc, 32'hFFFF_FFFC);
    bus.MC_valid = 1'b0;
    step();
    step();
`ifdef ICACHE_EN
    chk("hit_push", {31'b0, bus.IF_S}, 32'd1);
    chk("hit_no_req", {31'b0, bus.MC_req}, 32'd0);
    chk("hit_pc", bus.IF_pc, 32'h0);
    chk("hit_inst", bus.IF_Inst, 32'h13);
`else
    chk("wrap0_req", {31'b0, bus.MC_req}, 32'd1);
    chk("wrap0_addr", bus.MC_addr, 32'h0);
    chk("wrap0_if_s", {31'b0, bus.IF_S}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, meaning the PC loaded at reset.
REQ-002 SHALL have parameter ICACHE_LINES, default 256, meaning the number of direct-mapped I-cache lines; a power of 2.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports, one per line:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- clr  in  1  pipeline flush / redirect
- clr_pc  in  32  redirect target, valid with clr
- IQ_full  in  1  instruction queue full
- IF_S  out  1  one-cycle push strobe to queue
- IF_Inst  out  32  pushed instruction
- IF_pc  out  32  PC of pushed instruction
- MC_req  out  1  memory fetch request, held until MC_valid
- MC_addr  out  32  fetch address
- MC_valid  in  1  fetch complete, one-cycle pulse
- MC_inst  in  32  fetched word, valid with MC_valid

Function
REQ-005 SHALL use a state machine with states IDLE and WAIT_MEM, plus a 1-bit discard flag.
REQ-006 In IDLE, SHALL issue only when all of these hold: rdy=1, clr=0, IQ_full=0 and IF_S=0, so at most one push is in flight.
REQ-007 On issue with a miss, or with the cache compiled out, SHALL assert MC_req=1 and MC_addr=pc on the next edge, then go to WAIT_MEM.
REQ-008 In WAIT_MEM, SHALL hold MC_req and MC_addr constant until MC_valid.
REQ-009 On MC_valid with discard=0, SHALL on the same edge:
- set IF_S=1, IF_Inst=MC_inst, IF_pc=MC_addr;
- set pc=pc+4;
- drop MC_req and return to IDLE.
REQ-010 On MC_valid with discard=1, SHALL push nothing, clear discard, drop MC_req and return to IDLE.
REQ-011 IF_S SHALL be high for exactly one cycle per push; IF_Inst and IF_pc SHALL hold their values otherwise.
REQ-012 On clr=1 with rdy=1, SHALL on the next edge:
- load pc=clr_pc;
- force IF_S=0, overriding any push that edge;
- if in WAIT_MEM, or entering it, set discard=1 and keep MC_req asserted.
REQ-013 clr SHALL take priority over issue and over MC_valid delivery in the same cycle; a same-cycle MC_valid in WAIT_MEM is consumed as discarded.
REQ-014 With rdy=0, SHALL hold state, pc, MC_req and MC_addr, and drive IF_S=0.
REQ-015 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
REQ-016 Miss fetch latency SHALL be: MC_req 1 cycle after issue; IF_S on the edge after MC_valid.

Reset
REQ-017 On rst, asynchronously, SHALL set:
- pc=RESET_PC;
- state=IDLE, discard=0;
- IF_S=0, IF_Inst=0, IF_pc=0;
- MC_req=0, MC_addr=0;
- all cache valid bits=0.
REQ-018 Reset during WAIT_MEM SHALL abandon the request; a late MC_valid arriving in IDLE SHALL be ignored.

Configuration
REQ-019 Macro ICACHE_EN SHALL, when defined, compile in a direct-mapped I-cache with the following behaviour:
- index = pc[log2(ICACHE_LINES)+1:2]; tag = the remaining upper bits; one valid bit per line;
- a hit at issue pushes the cached word on the next edge (IF_S=1, pc+=4) with no MC_req;
- a line is filled on every MC_valid, including discarded ones.
REQ-020 Without ICACHE_EN, every issue SHALL go to memory; no cache storage SHALL exist.
REQ-021 clr SHALL NOT invalidate the cache; only rst SHALL.

Structure
REQ-022 Shared package SHALL hold: state encoding, 32-bit InstBus and AddrBus widths, the PC increment of 4, and the RESET_PC default.
REQ-023 The cache SHALL be a sub-module icache (lookup port plus fill port) that is instantiated only under ICACHE_EN.

Verification
REQ-024 Reset, then MC_valid after 3 cycles with MC_inst=32'h00000013 -> IF_S pulse with IF_pc=0, IF_Inst=32'h13, next MC_addr=4.
REQ-025 IQ_full=1 held for 10 cycles -> MC_req=0 and IF_S=0 throughout; the fetch of pc resumes 1 cycle after IQ_full falls.
REQ-026 clr with clr_pc=32'h100 during WAIT_MEM for pc=8 -> the MC_valid word is not pushed; next MC_addr=32'h100.
REQ-027 clr with clr_pc=32'h40 on the same cycle as MC_valid -> no IF_S; pc=32'h40.
REQ-028 rdy=0 for 5 cycles while in WAIT_MEM -> MC_req and MC_addr stable; no IF_S.
REQ-029 With ICACHE_EN, loop pc 0->4->0 via clr -> second fetch of pc=0 pushes without MC_req, 1 cycle after issue.
